rnn_mem_responder: RTL
======================

RNN_MEM_RESPONDER -- requirements
Module: rnn_mem_responder

Interface
REQ-001 SHALL have parameter OUT_DEPTH, default 4096: output (msel=101) bank words; writes at maddr >= OUT_DEPTH are dropped.
REQ-002 SHALL have parameter IN_DEPTH, default 16, power of two: idata show-ahead FIFO depth in 32-bit words.
REQ-003 SHALL have ports clk in 1 (single clock, all flops rising edge) and reset_n in 1; reset is asynchronous and active-low.
REQ-004 SHALL have ports busy in 1, i_en in 1, mce in 1, maddr in 17, mdata_w in 20, msel in 3 (core-side request) and ready out 1, idata out 32, mdata_r out 20 (core-side response).
REQ-005 SHALL have host ports ld_valid in 1, ld_sel in 3, ld_addr in 17, ld_data in 20 (bank preload), in_push in 1, in_data in 32, in_full out 1 (idata FIFO fill), start in 1, done out 1, wr_count out 17, rd_addr in 17, rd_data out 20 (output readback), err out 1.

Function
REQ-006 Banks by msel: 000 W_ih 2048 words at maddr[10:0]; 001 b_ih 64 at maddr[5:0]; 010 W_hh 4096 at maddr[11:0]; 011 b_hh 64 at maddr[5:0]; 100 T, one word (step count) at any address; 101 output, OUT_DEPTH words, write-only from core; 110/111 unmapped.
REQ-007 mdata_r SHALL be combinational from msel/maddr (zero-cycle read): the core drives maddr at edge k and samples mdata_r at edge k+1.
REQ-008 mdata_r = 0 when mce=0, msel is 101, 110 or 111, or busy=0.
REQ-009 On a clk edge with mce=1 and msel=101, write mdata_w to output[maddr] and increment wr_count, saturating at 17'h1FFFF; no write when maddr >= OUT_DEPTH.
REQ-010 idata SHALL present the FIFO head word, or 0 when empty; a clk edge with i_en=1 and FIFO non-empty pops one word; the core consumes the word shown while i_en is high.
REQ-011 in_push with in_full=0 appends in_data; a simultaneous push and pop SHALL both take effect; a push while full is dropped and sets err.
REQ-012 FSM states IDLE, ARM, RUN, DONE; reset enters IDLE.
REQ-013 IDLE: ld_valid writes ld_data to bank ld_sel at ld_addr (sel 101 included); start=1 with FIFO non-empty -> ARM; start with FIFO empty is ignored.
REQ-014 ARM lasts exactly one cycle with ready=1, then -> RUN; ready=0 in every other state.
REQ-015 RUN: waits for busy=1, then for busy=0; on the falling edge of busy -> DONE; ld_valid in RUN or ARM is ignored and sets err.
REQ-016 DONE: done=1 held; start -> ARM (FIFO non-empty) else IDLE; wr_count is cleared on every ARM entry.
REQ-017 i_en=1 with FIFO empty SHALL set err (underflow); err is sticky until reset.
REQ-018 rd_data SHALL be combinational output[rd_addr], 0 when rd_addr >= OUT_DEPTH.

Reset
REQ-019 reset_n=0 SHALL immediately force ready=0, done=0, err=0, wr_count=0, FIFO empty (idata=0, in_full=0), state IDLE, also mid-RUN; bank contents are not reset.

Configuration
REQ-020 Macro RNN_RSP_RANGE_CHK_EN defined: a core access with mce=1 at an address beyond its bank size (001/011 maddr > 63, 000 > 2047, 010 > 4095, 101 >= OUT_DEPTH) or to msel 110/111 sets err; not defined: these accesses alias or drop per REQ-006/REQ-009 and never set err.

Verification
REQ-021 Preload W_ih[5]=20'h00123 via ld port; in RUN drive mce=1, msel=000, maddr=5 -> mdata_r=20'h00123 in the same cycle; mce=0 -> mdata_r=0.
REQ-022 Push 32'hA5A5_0001 and 32'h0000_FFFF, start -> ready high exactly one cycle; idata=32'hA5A5_0001; i_en high one edge -> idata=32'h0000_FFFF.
REQ-023 RUN with mce=1, msel=101, maddr=17'h0041, mdata_w=20'hF0000 -> rd_data at rd_addr=17'h0041 returns 20'hF0000; wr_count=1.
REQ-024 Busy 0->1->0 -> done=1 next cycle; start with FIFO empty -> IDLE, done=0.
REQ-025 Assert reset_n=0 mid-RUN after 3 writes -> wr_count=0, state IDLE, err=0 with no clock edge; output[] retains written data.
REQ-026 With RNN_RSP_RANGE_CHK_EN: msel=001, maddr=64 -> err=1; without it: same access -> mdata_r=b_ih[0], err=0.

Source files
------------

// File: rtl/rnn_mem_responder.sv
// rnn_mem_responder
// Memory-side responder for an RNN core. Holds the weight/bias banks, the
// step count T and the output bank; feeds input words to the core through a
// show-ahead FIFO and sequences a run with an IDLE/ARM/RUN/DONE controller.
//
// Ports
//   clk, reset_n        : single rising-edge clock, async active-low reset
//   busy, i_en, mce,
//   maddr, mdata_w, msel: core-side request
//   ready, idata,
//   mdata_r             : core-side response (mdata_r is a zero-cycle read)
//   ld_*                : host bank preload (accepted in IDLE only)
//   in_push, in_data,
//   in_full             : host fill of the idata FIFO
//   start, done         : run control
//   wr_count            : saturating count of core writes to the output bank
//   rd_addr, rd_data    : host readback of the output bank
//   err                 : sticky error flag
//
// Build option
//   RNN_RSP_RANGE_CHK_EN : when defined, core accesses outside a bank (or to
//                          msel 110/111) set err; otherwise they alias/drop.
module rnn_mem_responder #(
    parameter int OUT_DEPTH = 4096,
    parameter int IN_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        busy,
    input  logic        i_en,
    input  logic        mce,
    input  logic [16:0] maddr,
    input  logic [19:0] mdata_w,
    input  logic [2:0]  msel,
    output logic        ready,
    output logic [31:0] idata,
    output logic [19:0] mdata_r,
    input  logic        ld_valid,
    input  logic [2:0]  ld_sel,
    input  logic [16:0] ld_addr,
    input  logic [19:0] ld_data,
    input  logic        in_push,
    input  logic [31:0] in_data,
    output logic        in_full,
    input  logic        start,
    output logic        done,
    output logic [16:0] wr_count,
    input  logic [16:0] rd_addr,
    output logic [19:0] rd_data,
    output logic        err
);
    localparam int OAW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int IAW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [17:0]    OUT_LIM   = 18'(OUT_DEPTH);
    localparam logic [IAW:0]   FIFO_FULL = (IAW + 1)'(IN_DEPTH);
    localparam logic [IAW-1:0] PTR_LAST  = IAW'(IN_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    // Bank storage (not reset)
    logic [19:0] w_ih_mem [2048];
    logic [19:0] b_ih_mem [64];
    logic [19:0] w_hh_mem [4096];
    logic [19:0] b_hh_mem [64];
    logic [19:0] t_reg;
    logic [19:0] out_mem  [OUT_DEPTH];
    logic [31:0] fifo_mem [IN_DEPTH];

    state_t         state_q, state_d;
    logic           seen_busy_q, seen_busy_d;
    logic           ready_q, ready_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [16:0]    wr_count_q, wr_count_d;
    logic [IAW-1:0] rd_ptr_q, rd_ptr_d;
    logic [IAW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IAW:0]   cnt_q, cnt_d;

    logic fifo_empty, fifo_full, push, pop;
    logic ld_we, core_we, range_err;

    function automatic logic out_hit(input logic [16:0] a);
        return {1'b0, a} < OUT_LIM;
    endfunction

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FIFO_FULL);
    assign push       = in_push && !fifo_full;
    assign pop        = i_en && !fifo_empty;
    assign ld_we      = ld_valid && (state_q == IDLE);
    assign core_we    = mce && (msel == 3'b101) && out_hit(maddr);

`ifdef RNN_RSP_RANGE_CHK_EN
    always_comb begin
        range_err = 1'b0;
        if (mce) begin
            unique case (msel)
                3'b000:         range_err = (maddr[16:11] != '0);
                3'b001, 3'b011: range_err = (maddr[16:6] != '0);
                3'b010:         range_err = (maddr[16:12] != '0);
                3'b100:         range_err = 1'b0;
                3'b101:         range_err = !out_hit(maddr);
                default:        range_err = 1'b1;
            endcase
        end
    end
`else
    assign range_err = 1'b0;
`endif

    // Zero-cycle bank read
    always_comb begin
        mdata_r = '0;
        if (mce && busy) begin
            unique case (msel)
                3'b000:  mdata_r = w_ih_mem[maddr[10:0]];
                3'b001:  mdata_r = b_ih_mem[maddr[5:0]];
                3'b010:  mdata_r = w_hh_mem[maddr[11:0]];
                3'b011:  mdata_r = b_hh_mem[maddr[5:0]];
                3'b100:  mdata_r = t_reg;
                default: mdata_r = '0;
            endcase
        end
    end

    assign rd_data  = out_hit(rd_addr) ? out_mem[rd_addr[OAW-1:0]] : '0;
    assign idata    = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
    assign in_full  = fifo_full;
    assign ready    = ready_q;
    assign done     = done_q;
    assign err      = err_q;
    assign wr_count = wr_count_q;

    always_ff @(posedge clk) begin
        if (ld_we) begin
            unique case (ld_sel)
                3'b000:  w_ih_mem[ld_addr[10:0]] <= ld_data;
                3'b001:  b_ih_mem[ld_addr[5:0]]  <= ld_data;
                3'b010:  w_hh_mem[ld_addr[11:0]] <= ld_data;
                3'b011:  b_hh_mem[ld_addr[5:0]]  <= ld_data;
                3'b100:  t_reg <= ld_data;
                3'b101:  if (out_hit(ld_addr)) out_mem[ld_addr[OAW-1:0]] <= ld_data;
                default: ;
            endcase
        end
        if (core_we) out_mem[maddr[OAW-1:0]] <= mdata_w;
        if (push)    fifo_mem[wr_ptr_q] <= in_data;
    end

    always_comb begin
        state_d     = state_q;
        seen_busy_d = seen_busy_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        wr_count_d  = wr_count_q;

        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;

        unique case (state_q)
            IDLE: if (start && !fifo_empty) state_d = ARM;
            ARM: begin
                state_d     = RUN;
                seen_busy_d = 1'b0;
            end
            // Wait for busy to rise, then leave on its fall
            RUN: begin
                if (!seen_busy_q)  seen_busy_d = busy;
                else if (!busy)    state_d = DONE;
            end
            DONE: if (start) state_d = fifo_empty ? IDLE : ARM;
            default: state_d = IDLE;
        endcase

        if (core_we && (wr_count_q != '1)) wr_count_d = wr_count_q + 1'b1;
        // ARM never self-loops, so state_d == ARM marks ARM entry
        if (state_d == ARM) wr_count_d = '0;

        ready_d = (state_d == ARM);
        done_d  = (state_d == DONE);
        err_d   = err_q
                | (in_push && fifo_full)
                | (i_en && fifo_empty)
                | (ld_valid && (state_q == ARM || state_q == RUN))
                | range_err;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            seen_busy_q <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wr_count_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            seen_busy_q <= seen_busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wr_count_q  <= wr_count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
        end
    end
endmodule
